// File: rtl/stopwatch_seq_ctrl.sv
// stopwatch_seq_ctrl
// Sequencing controller for the 0-9999 stopwatch counter datapath. Owns
// run/stop, clear, count direction and lap hold, and picks the value shown
// on the FND display.
//
// Optional feature macro: STOPWATCH_AUTO_STOP_EN
//   defined   : terminal-count detection on i_tick stops the run at 9999 (up)
//               or 0 (down)
//   undefined : no terminal detection, the counter wraps, i_tick is unused
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   i_run_stop   run/stop pulse (1 cycle)
//   i_clear      clear pulse (1 cycle)
//   i_lap        lap pulse (1 cycle)
//   i_mode       direction switch level, 0 = up, 1 = down
//   i_tick       10 Hz tick that also drives the counter
//   i_count      live counter value
//   o_run_stop   counter enable level
//   o_clear      one-cycle clear pulse to the counter
//   o_mode       latched direction
//   o_disp_data  value sent to the display
//   o_lap_active high while the display is frozen
//   o_state      current state code
//
// state | meaning
// IDLE  | cleared, waiting for run
// RUN   | counting, display live
// STOP  | paused, display live
// LAP   | counting, display frozen on lap register
// CLEAR | one-cycle clear pulse, then IDLE
module stopwatch_seq_ctrl #(
  parameter int WIDTH     = 14,
  parameter int MAX_COUNT = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run_stop,
  input  logic             i_clear,
  input  logic             i_lap,
  input  logic             i_mode,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_run_stop,
  output logic             o_clear,
  output logic             o_mode,
  output logic [WIDTH-1:0] o_disp_data,
  output logic             o_lap_active,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STOP  = 3'd2,
    S_LAP   = 3'd3,
    S_CLEAR = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             run_stop_q, run_stop_d;
  logic             clear_q, clear_d;
  logic             mode_q, mode_d;
  logic             lap_active_q, lap_active_d;
  logic [WIDTH-1:0] lap_q, lap_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             term_hit;

`ifdef STOPWATCH_AUTO_STOP_EN
  // The tick that moves the counter onto its end value also stops the run,
  // so the counter lands on 9999 / 0 and stays there.
  always_comb begin
    term_hit = 1'b0;
    if (i_tick) begin
      if (!mode_q && (i_count == WIDTH'(MAX_COUNT - 1))) term_hit = 1'b1;
      if (mode_q && (i_count == WIDTH'(1)))              term_hit = 1'b1;
    end
  end
`else
  logic tick_unused;
  assign tick_unused = i_tick;
  assign term_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_STOP: begin
        if (i_clear)         state_d = S_CLEAR;
        else if (i_run_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (term_hit || i_run_stop) begin
          state_d = S_STOP;
        end else if (i_lap) begin
          state_d = S_LAP;
          lap_d   = i_count;
        end
      end
      S_LAP: begin
        if (term_hit || i_run_stop) state_d = S_STOP;
        else if (i_lap)             state_d = S_RUN;
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Direction is frozen while counting; a flip takes effect once stopped.
    if (state_q == S_IDLE || state_q == S_STOP || state_q == S_CLEAR) mode_d = i_mode;
    if (state_d == S_CLEAR) lap_d = '0;

    // Outputs are decoded from the next state so they line up with state_q.
    run_stop_d   = (state_d == S_RUN) || (state_d == S_LAP);
    clear_d      = (state_d == S_CLEAR);
    lap_active_d = (state_d == S_LAP);
    disp_d       = lap_active_d ? lap_d : i_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      run_stop_q   <= 1'b0;
      clear_q      <= 1'b0;
      mode_q       <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_stop_q   <= run_stop_d;
      clear_q      <= clear_d;
      mode_q       <= mode_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
      disp_q       <= disp_d;
    end
  end

  assign o_run_stop   = run_stop_q;
  assign o_clear      = clear_q;
  assign o_mode       = mode_q;
  assign o_lap_active = lap_active_q;
  assign o_disp_data  = disp_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
module tb_stopwatch_seq_ctrl;
  localparam int W    = 14;
  localparam int MAXC = 9999;

  logic         clk;
  logic         reset;
  logic         i_run_stop, i_clear, i_lap, i_mode, i_tick;
  logic [W-1:0] i_count;
  logic         o_run_stop, o_clear, o_mode, o_lap_active;
  logic [W-1:0] o_disp_data;
  logic [2:0]   o_state;

  int errors = 0;
  int checks = 0;

  // reference model: stopwatch-level view (0 idle, 1 run, 2 stop, 3 lap, 4 clear)
  int         m_st;
  bit         m_mode;
  int         m_lap;
  int         m_disp;

  stopwatch_seq_ctrl #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .reset(reset),
    .i_run_stop(i_run_stop), .i_clear(i_clear), .i_lap(i_lap),
    .i_mode(i_mode), .i_tick(i_tick), .i_count(i_count),
    .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode),
    .o_disp_data(o_disp_data), .o_lap_active(o_lap_active), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+6:0] model_vec();
    logic [W+6:0] v;
    v = {3'(m_st), (m_st == 1 || m_st == 3), (m_st == 4), m_mode, (m_st == 3), W'(m_disp)};
    return v;
  endfunction

  function automatic logic [W+6:0] dut_vec();
    return {o_state, o_run_stop, o_clear, o_mode, o_lap_active, o_disp_data};
  endfunction

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_lap = 0; m_disp = 0;
  endtask

  task automatic model_edge();
    int nxt;
    bit hit;
    hit = 0;
`ifdef STOPWATCH_AUTO_STOP_EN
    if (i_tick && (m_st == 1 || m_st == 3))
      hit = m_mode ? (int'(i_count) == 1) : (int'(i_count) == MAXC - 1);
`endif
    case (m_st)
      0, 2:    nxt = i_clear ? 4 : (i_run_stop ? 1 : m_st);
      1:       nxt = (hit || i_run_stop) ? 2 : (i_lap ? 3 : 1);
      3:       nxt = (hit || i_run_stop) ? 2 : (i_lap ? 1 : 3);
      default: nxt = 0;
    endcase
    if (m_st == 0 || m_st == 2 || m_st == 4) m_mode = i_mode;
    if (m_st == 1 && nxt == 3) m_lap = int'(i_count);
    if (nxt == 4) m_lap = 0;
    m_st   = nxt;
    m_disp = (nxt == 3) ? m_lap : int'(i_count);
  endtask

  // one clock: drive inputs on the falling edge, advance model, settle
  task automatic cycle(input bit rs, input bit cl, input bit lp, input bit tk, input int cnt);
    @(negedge clk);
    i_run_stop = rs; i_clear = cl; i_lap = lp; i_tick = tk; i_count = W'(cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_run_stop = 0; i_clear = 0; i_lap = 0; i_tick = 0; i_count = '0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    do_reset();
    i_mode = 0;
    cycle(1, 0, 0, 0, 'h123);
    cycle(0, 0, 0, 0, 'h123);
    checks++;
    if (o_state !== 3'd1) begin errors++; $display("FAIL reset_pre_run: state %0d want 1", o_state); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== '0) begin
        errors++; $display("FAIL reset_hold: cycle %0d got %h want 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_run_stop_clear();
    cycle(1, 0, 0, 0, 5);
    checks++;
    if (o_state !== 3'd1 || o_run_stop !== 1'b1) begin
      errors++; $display("FAIL run: state %0d run %0b want 1 1", o_state, o_run_stop);
    end
    cycle(1, 0, 0, 0, 6);
    checks++;
    if (o_state !== 3'd2 || o_run_stop !== 1'b0) begin
      errors++; $display("FAIL stop: state %0d run %0b want 2 0", o_state, o_run_stop);
    end
    cycle(0, 1, 0, 0, 6);
    checks++;
    if (o_state !== 3'd4 || o_clear !== 1'b1) begin
      errors++; $display("FAIL clear_pulse: state %0d clear %0b want 4 1", o_state, o_clear);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (o_state !== 3'd0 || o_clear !== 1'b0) begin
      errors++; $display("FAIL clear_end: state %0d clear %0b want 0 0", o_state, o_clear);
    end
  endtask

  task automatic test_lap();
    cycle(1, 0, 0, 0, 40);
    cycle(0, 0, 0, 0, 41);
    cycle(0, 0, 1, 0, 42);
    checks++;
    if (o_state !== 3'd3 || o_lap_active !== 1'b1 || o_disp_data !== W'(42)) begin
      errors++; $display("FAIL lap_enter: state %0d lap %0b disp %0d want 3 1 42", o_state, o_lap_active, o_disp_data);
    end
    for (int c = 43; c <= 57; c++) begin
      cycle(0, 0, 0, 0, c);
      checks++;
      if (o_disp_data !== W'(42) || o_run_stop !== 1'b1) begin
        errors++; $display("FAIL lap_hold: count %0d disp %0d run %0b want 42 1", c, o_disp_data, o_run_stop);
      end
    end
    cycle(0, 0, 1, 0, 58);
    checks++;
    if (o_state !== 3'd1 || o_lap_active !== 1'b0 || o_disp_data !== W'(58)) begin
      errors++; $display("FAIL lap_release: state %0d lap %0b disp %0d want 1 0 58", o_state, o_lap_active, o_disp_data);
    end
    cycle(0, 0, 0, 0, 59);
    checks++;
    if (o_disp_data !== W'(59)) begin
      errors++; $display("FAIL live_disp: disp %0d want 59", o_disp_data);
    end
    cycle(1, 0, 0, 0, 59);
    cycle(0, 1, 0, 0, 59);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_mode_hold();
    i_mode = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    i_mode = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, i + 1);
      checks++;
      if (o_mode !== 1'b0) begin errors++; $display("FAIL mode_held: got %0b want 0", o_mode); end
    end
    cycle(1, 0, 0, 0, 4);
    cycle(0, 0, 0, 0, 4);
    checks++;
    if (o_state !== 3'd2 || o_mode !== 1'b1) begin
      errors++; $display("FAIL mode_at_stop: state %0d mode %0b want 2 1", o_state, o_mode);
    end
    i_mode = 0;
    cycle(0, 1, 0, 0, 4);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (o_mode !== 1'b0 || o_state !== 3'd0) begin
      errors++; $display("FAIL mode_back: mode %0b state %0d want 0 0", o_mode, o_state);
    end
  endtask

  task automatic test_priority();
    cycle(1, 0, 0, 0, 10);
    cycle(0, 1, 0, 0, 11);
    checks++;
    if (o_state !== 3'd1 || o_clear !== 1'b0) begin
      errors++; $display("FAIL clear_in_run: state %0d clear %0b want 1 0", o_state, o_clear);
    end
    cycle(1, 0, 1, 0, 12);
    checks++;
    if (o_state !== 3'd2 || o_lap_active !== 1'b0) begin
      errors++; $display("FAIL rs_over_lap: state %0d lap %0b want 2 0", o_state, o_lap_active);
    end
    cycle(1, 1, 0, 0, 12);
    checks++;
    if (o_state !== 3'd4 || o_run_stop !== 1'b0 || o_clear !== 1'b1) begin
      errors++; $display("FAIL clear_over_rs: state %0d run %0b clear %0b want 4 0 1", o_state, o_run_stop, o_clear);
    end
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (o_state !== 3'd0 || o_run_stop !== 1'b0) begin
      errors++; $display("FAIL drop_in_clear: state %0d run %0b want 0 0", o_state, o_run_stop);
    end
  endtask

  task automatic test_auto_stop();
    bit en;
`ifdef STOPWATCH_AUTO_STOP_EN
    en = 1;
`else
    en = 0;
`endif
    i_mode = 0;
    do_reset();
    cycle(1, 0, 0, 0, 9990);
    cycle(0, 0, 0, 1, 9998);
    checks++;
    if (o_state !== (en ? 3'd2 : 3'd1) || o_run_stop !== !en) begin
      errors++; $display("FAIL term_up: state %0d run %0b want %0d %0b", o_state, o_run_stop, en ? 2 : 1, !en);
    end
    i_mode = 1;
    do_reset();
    cycle(0, 0, 0, 0, 5);
    cycle(1, 0, 0, 0, 5);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (o_mode !== 1'b1 || o_state !== (en ? 3'd2 : 3'd1)) begin
      errors++; $display("FAIL term_down: state %0d mode %0b want %0d 1", o_state, o_mode, en ? 2 : 1);
    end
    do_reset();
    cycle(0, 0, 0, 0, 5);
    cycle(1, 0, 0, 0, 5);
    cycle(0, 0, 1, 0, 3);
    cycle(1, 0, 0, 1, 1);
    checks++;
    if (o_state !== 3'd2 || o_lap_active !== 1'b0) begin
      errors++; $display("FAIL term_with_rs: state %0d lap %0b want 2 0", o_state, o_lap_active);
    end
    i_mode = 0;
    do_reset();
  endtask

  task automatic test_random();
    int cnt;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
      case ($urandom_range(0, 7))
        0:       cnt = m_mode ? 1 : MAXC - 1;
        1:       cnt = m_mode ? MAXC - 1 : 1;
        default: cnt = $urandom_range(0, MAXC);
      endcase
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, cnt);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random: cycle %0d got st=%0d run=%0b clr=%0b mode=%0b lap=%0b disp=%0d want st=%0d mode=%0b disp=%0d",
                 i, o_state, o_run_stop, o_clear, o_mode, o_lap_active, o_disp_data, m_st, m_mode, m_disp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    i_run_stop = 0; i_clear = 0; i_lap = 0; i_mode = 0; i_tick = 0; i_count = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_run_stop_clear();
    test_lap();
    test_mode_hold();
    test_priority();
    test_auto_stop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_seq_ctrl.md
Name: stopwatch_seq_ctrl

Overview:
Sequencing controller for the 0–9999 stopwatch counter datapath. It sits between the debounced button pulses, the up/down mode switch, the 10 Hz tick generator, the counter and the FND controller. It owns run/stop, clear, direction and lap-hold state, and selects the value sent to the display. It replaces the ad-hoc control_unit with a defined FSM, lap freeze, and guarded mode changes.

Parameters:
WIDTH, 14, counter/display data width
MAX_COUNT, 9999, terminal count of the up direction; the down direction terminates at 0

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
i_run_stop  in  1  one-cycle debounced run/stop pulse
i_clear  in  1  one-cycle debounced clear pulse
i_lap  in  1  one-cycle debounced lap pulse
i_mode  in  1  direction switch level: 0 = up, 1 = down
i_tick  in  1  one-cycle 10 Hz tick, the same pulse that drives the counter
i_count  in  WIDTH  live counter value
o_run_stop  out  1  counter/tick enable level
o_clear  out  1  one-cycle clear pulse to the counter
o_mode  out  1  latched direction to the counter
o_disp_data  out  WIDTH  value to fnd_controller
o_lap_active  out  1  high while the display is frozen
o_state  out  3  current FSM state encoding, for debug/LED

Behaviour:
- Reset (reset low, asynchronous) sets:
  - state = IDLE
  - o_run_stop = 0, o_clear = 0, o_lap_active = 0
  - o_mode = 0
  - o_disp_data = 0
  - lap register = 0
- State encodings: IDLE = 0, RUN = 1, STOP = 2, LAP = 3, CLEAR = 4. Unused codes go to IDLE.
- Transitions are evaluated on the rising edge of clk. Pulse priority within a state: clear > run_stop > lap.
  - IDLE: i_clear -> CLEAR; i_run_stop -> RUN; i_lap ignored.
  - RUN: i_run_stop -> STOP; i_lap -> LAP and capture i_count into the lap register on the same edge; i_clear ignored.
  - LAP: i_run_stop -> STOP and release the hold; i_lap -> RUN and release the hold; i_clear ignored.
  - STOP: i_clear -> CLEAR; i_run_stop -> RUN; i_lap ignored.
  - CLEAR: unconditional -> IDLE after exactly one cycle; all pulses that arrive in CLEAR are dropped.
- Outputs:
  - o_run_stop is a Moore output, 1 in RUN and LAP, otherwise 0. It is valid the cycle after the transition edge.
  - o_clear is 1 only in CLEAR, so a one-cycle pulse. The lap register is cleared on the same edge.
- Mode:
  - o_mode samples i_mode every cycle in IDLE, STOP and CLEAR.
  - o_mode is held in RUN and LAP. A switch flip while running takes effect at the next stop.
- Display:
  - o_disp_data is registered: it equals the lap register when o_lap_active = 1, otherwise i_count.
  - Live display latency is 1 clk.
  - o_lap_active = 1 exactly in LAP.
- i_tick is used only by the optional feature. Counting itself is unaffected by this block except via o_run_stop, o_clear and o_mode.
- Reset mid-operation aborts any state immediately; no pulse is remembered.

Optional Feature:
STOPWATCH_AUTO_STOP_EN
- Defined:
  - In RUN or LAP, when i_tick = 1 and (o_mode = 0 and i_count = MAX_COUNT-1) or (o_mode = 1 and i_count = 1), the FSM goes to STOP on that edge. The counter lands on 9999 or 0 and stays there.
  - A held lap is released when this happens.
  - Simultaneous i_run_stop on that edge gives the same result (STOP).
- Undefined: no terminal detection; the counter wraps freely (9999 -> 0 up, 0 -> 9999 down) and i_tick is unused.

Test Plan:
- Reset low mid-RUN with i_count = 0x0123 -> all outputs 0 and o_state = 0 asynchronously; they stay there after release until a pulse arrives.
- IDLE, then i_run_stop pulse -> o_run_stop = 1 one cycle later, o_state = 1. A second pulse -> o_run_stop = 0, o_state = 2. Then i_clear -> o_clear high for exactly 1 cycle, then o_state = 0.
- RUN with i_count = 42, i_lap pulse -> o_disp_data holds 42 while i_count advances to 57. Next i_lap -> o_disp_data tracks i_count again with 1-cycle latency.
- RUN with o_mode = 0, flip i_mode to 1 -> o_mode stays 0. i_run_stop -> o_mode = 1 within 2 cycles of entering STOP.
- STOP, with i_clear and i_run_stop asserted in the same cycle -> CLEAR wins, then IDLE, o_run_stop stays 0. i_clear pulse during RUN -> ignored, no o_clear.
- With the macro defined, o_mode = 0, i_count = 9998, i_tick -> o_state = 2 next cycle, o_run_stop = 0. Down mode with i_count = 1 and i_tick -> STOP. With the macro undefined, the same stimulus keeps RUN.
